// File: rtl/sample_buf_reader.sv
// sample_buf_reader: reads packed capture bytes from BSRAM and
// streams them out LSB-first as a 1-bit valid/ready sample stream.
module sample_buf_reader #(
   parameter int ADDR_W = 14,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W:0]   byte_count,
   input  logic              abort,
   output logic              mem_ce,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic              samp_valid,
   input  logic              samp_ready,
   output logic              samp_i,
   output logic              samp_last,
   output logic              busy,
   output logic              done
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   localparam logic [ADDR_W-1:0] A_ONE = 1;
   localparam logic [ADDR_W:0]   C_ONE = 1;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   fetch_rem_q, fetch_rem_d;
   logic [ADDR_W:0]   load_rem_q, load_rem_d;
   logic [RD_LAT-1:0] pipe_q, pipe_d;
   logic [RD_LAT-1:0] pipe_sh;
   logic [7:0]        pf_q, pf_d;
   logic              pf_vld_q, pf_vld_d;
   logic [7:0]        sh_q, sh_d;
   logic [2:0]        idx_q, idx_d;
   logic              sh_vld_q, sh_vld_d;
   logic              done_q, done_d;

   logic hs;
   logic sh_load;
   logic capture;
   logic fetch;
   logic last_hs;

   // tag pipe shifts the new read tag in at the bottom
   if (RD_LAT > 1) begin : g_pipe_deep
      assign pipe_sh = {pipe_q[RD_LAT-2:0], fetch};
   end else begin : g_pipe_one
      assign pipe_sh = fetch;
   end

   // handshake, reload and fetch-issue decisions for this cycle
   always_comb begin
      hs      = sh_vld_q & samp_ready;
      sh_load = pf_vld_q & (~sh_vld_q | (hs & (idx_q == 3'd7)));
      capture = pipe_q[RD_LAT-1];
      fetch   = (state_q == RUN) & ~abort
              & (fetch_rem_q != '0)
              & (pipe_q == '0)
              & (~pf_vld_q | sh_load);
      last_hs = hs & samp_last;
   end

   // next-state for controller, fetch engine, prefetch and shifter
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      fetch_rem_d = fetch_rem_q;
      load_rem_d  = load_rem_q;
      pipe_d      = pipe_sh;
      pf_d        = pf_q;
      pf_vld_d    = pf_vld_q;
      sh_d        = sh_q;
      idx_d       = idx_q;
      sh_vld_d    = sh_vld_q;
      done_d      = 1'b0;

      if (fetch) begin
         addr_d      = addr_q + A_ONE;
         fetch_rem_d = fetch_rem_q - C_ONE;
      end

      if (capture) begin
         pf_d     = mem_rdata;
         pf_vld_d = 1'b1;
      end else if (sh_load) begin
         pf_vld_d = 1'b0;
      end

      if (sh_load) begin
         sh_d       = pf_q;
         idx_d      = 3'd0;
         sh_vld_d   = 1'b1;
         load_rem_d = load_rem_q - C_ONE;
      end else if (hs) begin
         idx_d = idx_q + 3'd1;
         if (idx_q == 3'd7) begin
            sh_vld_d = 1'b0;
         end
      end

      unique case (state_q)
         IDLE: begin
            if (start && !abort) begin
               if (byte_count == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d     = RUN;
                  addr_d      = start_addr;
                  fetch_rem_d = byte_count;
                  load_rem_d  = byte_count;
               end
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
            end else if (last_hs) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
      endcase

      // leaving or staying in IDLE drops every buffered or
      // in-flight byte so late returns can never leak
      if (state_d == IDLE) begin
         pipe_d      = '0;
         pf_vld_d    = 1'b0;
         sh_vld_d    = 1'b0;
         idx_d       = 3'd0;
         fetch_rem_d = '0;
         load_rem_d  = '0;
      end
   end

   // state register with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         fetch_rem_q <= '0;
         load_rem_q  <= '0;
         pipe_q      <= '0;
         pf_q        <= '0;
         pf_vld_q    <= 1'b0;
         sh_q        <= '0;
         idx_q       <= 3'd0;
         sh_vld_q    <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         fetch_rem_q <= fetch_rem_d;
         load_rem_q  <= load_rem_d;
         pipe_q      <= pipe_d;
         pf_q        <= pf_d;
         pf_vld_q    <= pf_vld_d;
         sh_q        <= sh_d;
         idx_q       <= idx_d;
         sh_vld_q    <= sh_vld_d;
         done_q      <= done_d;
      end
   end

   assign mem_ce     = fetch;
   assign mem_addr   = addr_q;
   assign samp_valid = sh_vld_q;
   assign samp_i     = sh_q[idx_q];
   assign samp_last  = sh_vld_q & (load_rem_q == '0)
                     & (idx_q == 3'd7);
   assign busy       = (state_q == RUN);
   assign done       = done_q;

endmodule

// File: tb/tb_sample_buf_reader.sv
// tb_sample_buf_reader: directed bench for sample_buf_reader
// with a pipelined BSRAM model of latency LAT.
module tb_sample_buf_reader;

   localparam int AW  = 14;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] start_addr;
   logic [AW:0]   byte_count;
   logic          abort;
   logic          mem_ce;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_rdata;
   logic          samp_valid;
   logic          samp_ready;
   logic          samp_i;
   logic          samp_last;
   logic          busy;
   logic          done;

   logic [7:0] mem [0:(1<<AW)-1];
   logic [7:0] rd_pipe [0:LAT-1];

   int n_cmp = 0;
   int n_bad = 0;

   logic [127:0]  got_bits;
   int            n_s, last_n, last_pos;
   int            first_v, done_c, done_n;
   int            ce_n, busy_n, stall_err;
   logic [AW-1:0] ce_a [0:15];
   logic          busy0, ce0;

   always #5 clk = ~clk;

   sample_buf_reader #(.ADDR_W(AW), .RD_LAT(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_addr (start_addr),
      .byte_count (byte_count),
      .abort      (abort),
      .mem_ce     (mem_ce),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .samp_valid (samp_valid),
      .samp_ready (samp_ready),
      .samp_i     (samp_i),
      .samp_last  (samp_last),
      .busy       (busy),
      .done       (done)
   );

   // BSRAM model: junk 0xEE when not enabled, data LAT cycles later
   always @(posedge clk) begin
      rd_pipe[0] <= mem_ce ? mem[mem_addr] : 8'hEE;
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_rdata = rd_pipe[LAT-1];

   task automatic collect(input int max_c, input int pct,
                          input int poke_c,
                          input logic [AW-1:0] p_addr,
                          input logic [AW:0] p_cnt);
      logic pv, pi, pl;
      got_bits = '0; n_s = 0; last_n = 0; last_pos = -1;
      first_v = -1; done_c = -1; done_n = 0;
      ce_n = 0; busy_n = 0; stall_err = 0;
      busy0 = 1'b0; ce0 = 1'b0;
      pv = 1'b0; pi = 1'b0; pl = 1'b0;
      for (int c = 0; c < max_c; c++) begin
         samp_ready = (pct >= 100) ? 1'b1
                    : ($urandom_range(99) < pct);
         start = (c == poke_c);
         if (c == poke_c) begin
            start_addr = p_addr;
            byte_count = p_cnt;
         end
         @(negedge clk);
         if (c == 0) begin busy0 = busy; ce0 = mem_ce; end
         if (busy) busy_n++;
         if (mem_ce) begin
            if (ce_n < 16) ce_a[ce_n] = mem_addr;
            ce_n++;
         end
         if (samp_valid && first_v < 0) first_v = c;
         if (pv && (samp_valid !== 1'b1 || samp_i !== pi
                    || samp_last !== pl)) stall_err++;
         pv = samp_valid & ~samp_ready;
         pi = samp_i;
         pl = samp_last;
         if (samp_valid && samp_ready) begin
            if (n_s < 128) got_bits[n_s[6:0]] = samp_i;
            if (samp_last) begin last_n++; last_pos = n_s; end
            n_s++;
         end
         if (done) begin
            done_n++;
            if (done_c < 0) done_c = c;
         end
         @(posedge clk); #1;
         start = 1'b0;
         if (done_c >= 0 && c >= done_c + 2) break;
      end
   endtask

   task automatic test_reset();
      logic [AW+5:0] outs;
      rst = 1'b0; start = 1'b0; start_addr = '0; byte_count = '0;
      abort = 1'b0; samp_ready = 1'b0;
      #3;
      outs = {mem_ce, mem_addr, samp_valid, samp_i, samp_last, busy, done};
      n_cmp++; if (outs !== '0) begin n_bad++;
         $display("FAIL reset_outs got=%0h want=0", outs); end
      @(posedge clk); @(posedge clk); #1;
      outs = {mem_ce, mem_addr, samp_valid, samp_i, samp_last, busy, done};
      n_cmp++; if (outs !== '0) begin n_bad++;
         $display("FAIL reset_hold got=%0h want=0", outs); end
      rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++;
         $display("FAIL reset_idle_busy got=%0b want=0", busy); end
   endtask

   task automatic test_basic();
      mem[0] = 8'hA5; mem[1] = 8'h3C;
      start = 1'b1; start_addr = '0; byte_count = 2; samp_ready = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      collect(60, 100, -1, '0, '0);
      n_cmp++; if (busy0 !== 1'b1) begin n_bad++;
         $display("FAIL basic_busy got=%0b want=1", busy0); end
      n_cmp++; if (ce0 !== 1'b1) begin n_bad++;
         $display("FAIL basic_first_ce got=%0b want=1", ce0); end
      n_cmp++; if (n_s !== 16) begin n_bad++;
         $display("FAIL basic_count got=%0d want=16", n_s); end
      n_cmp++; if (got_bits[15:0] !== 16'h3CA5) begin n_bad++;
         $display("FAIL basic_bits got=%h want=3ca5", got_bits[15:0]); end
      n_cmp++; if (last_n !== 1 || last_pos !== 15) begin n_bad++;
         $display("FAIL basic_last got=%0d@%0d want=1@15", last_n, last_pos); end
      n_cmp++; if (first_v !== LAT + 2) begin n_bad++;
         $display("FAIL basic_latency got=%0d want=%0d", first_v, LAT + 2); end
      n_cmp++; if (done_c !== first_v + 16 || done_n !== 1) begin n_bad++;
         $display("FAIL basic_done got=%0d x%0d want=%0d x1",
                  done_c, done_n, first_v + 16); end
      n_cmp++; if (ce_n !== 2 || ce_a[0] !== 14'h0 || ce_a[1] !== 14'h1)
         begin n_bad++;
         $display("FAIL basic_fetch got=%0d %h %h want=2 0000 0001",
                  ce_n, ce_a[0], ce_a[1]); end
   endtask

   task automatic test_wrap();
      mem[14'h3FFF] = 8'h96; mem[0] = 8'hA5;
      start = 1'b1; start_addr = 14'h3FFF; byte_count = 2;
      @(posedge clk); #1; start = 1'b0;
      collect(60, 100, -1, '0, '0);
      n_cmp++; if (ce_n !== 2 || ce_a[0] !== 14'h3FFF || ce_a[1] !== 14'h0)
         begin n_bad++;
         $display("FAIL wrap_addr got=%0d %h %h want=2 3fff 0000",
                  ce_n, ce_a[0], ce_a[1]); end
      n_cmp++; if (got_bits[15:0] !== 16'hA596 || n_s !== 16) begin n_bad++;
         $display("FAIL wrap_bits got=%h/%0d want=a596/16",
                  got_bits[15:0], n_s); end
      n_cmp++; if (done_n !== 1) begin n_bad++;
         $display("FAIL wrap_done got=%0d want=1", done_n); end
   endtask

   task automatic test_backpressure();
      mem[14'h100] = 8'h5A; mem[14'h101] = 8'hC3;
      mem[14'h102] = 8'h0F; mem[14'h103] = 8'h81;
      start = 1'b1; start_addr = 14'h100; byte_count = 4;
      @(posedge clk); #1; start = 1'b0;
      collect(2000, 30, -1, '0, '0);
      samp_ready = 1'b1;
      n_cmp++; if (n_s !== 32 || got_bits[31:0] !== 32'h810FC35A)
         begin n_bad++;
         $display("FAIL bp_bits got=%h/%0d want=810fc35a/32",
                  got_bits[31:0], n_s); end
      n_cmp++; if (stall_err !== 0) begin n_bad++;
         $display("FAIL bp_stable got=%0d want=0", stall_err); end
      n_cmp++; if (ce_n !== 4) begin n_bad++;
         $display("FAIL bp_fetches got=%0d want=4", ce_n); end
      n_cmp++; if (last_n !== 1 || last_pos !== 31) begin n_bad++;
         $display("FAIL bp_last got=%0d@%0d want=1@31", last_n, last_pos); end
      n_cmp++; if (done_n !== 1) begin n_bad++;
         $display("FAIL bp_done got=%0d want=1", done_n); end
   endtask

   task automatic test_zero_len();
      start = 1'b1; start_addr = 14'h123; byte_count = 0;
      @(posedge clk); #1; start = 1'b0;
      collect(8, 100, -1, '0, '0);
      n_cmp++; if (done_c !== 0 || done_n !== 1) begin n_bad++;
         $display("FAIL zero_done got=%0d x%0d want=0 x1", done_c, done_n); end
      n_cmp++; if (first_v !== -1 || ce_n !== 0 || busy_n !== 0)
         begin n_bad++;
         $display("FAIL zero_quiet got=v%0d ce%0d b%0d want=v-1 ce0 b0",
                  first_v, ce_n, busy_n); end
   endtask

   task automatic test_abort();
      logic [3:0] outs;
      for (int i = 0; i < 10; i++) mem[14'h200 + i] = 8'hA0 + 8'(i);
      mem[14'h3000] = 8'hFF; mem[14'h400] = 8'h6D;
      abort = 1'b1; start = 1'b1; start_addr = 14'h3000; byte_count = 3;
      @(posedge clk); #1; abort = 1'b0; start = 1'b0;
      collect(6, 100, -1, '0, '0);
      n_cmp++; if (busy_n !== 0 || ce_n !== 0) begin n_bad++;
         $display("FAIL abort_wins got=b%0d ce%0d want=b0 ce0",
                  busy_n, ce_n); end
      start = 1'b1; start_addr = 14'h200; byte_count = 10;
      @(posedge clk); #1; start = 1'b0;
      collect(21, 100, -1, '0, '0);
      n_cmp++; if (n_s !== 17 || got_bits[16:0] !== 17'h0A1A0)
         begin n_bad++;
         $display("FAIL abort_pre got=%h/%0d want=0a1a0/17",
                  got_bits[16:0], n_s); end
      n_cmp++; if (done_n !== 0 || last_n !== 0) begin n_bad++;
         $display("FAIL abort_pre_done got=%0d/%0d want=0/0",
                  done_n, last_n); end
      abort = 1'b1; start = 1'b1; start_addr = 14'h3000; byte_count = 3;
      @(posedge clk); #1;
      abort = 1'b0; start = 1'b1; start_addr = 14'h400; byte_count = 1;
      @(negedge clk);
      outs = {busy, samp_valid, mem_ce, done};
      n_cmp++; if (outs !== 4'b0000) begin n_bad++;
         $display("FAIL abort_next got=%b want=0000", outs); end
      @(posedge clk); #1; start = 1'b0;
      collect(40, 100, -1, '0, '0);
      n_cmp++; if (ce_n !== 1 || ce_a[0] !== 14'h400) begin n_bad++;
         $display("FAIL abort_new_addr got=%0d %h want=1 0400",
                  ce_n, ce_a[0]); end
      n_cmp++; if (n_s !== 8 || got_bits[7:0] !== 8'h6D) begin n_bad++;
         $display("FAIL abort_new_bits got=%h/%0d want=6d/8",
                  got_bits[7:0], n_s); end
      n_cmp++; if (done_n !== 1 || first_v !== LAT + 2) begin n_bad++;
         $display("FAIL abort_new_done got=%0d v%0d want=1 v%0d",
                  done_n, first_v, LAT + 2); end
   endtask

   task automatic test_ignored_start();
      mem[14'h500] = 8'h33; mem[14'h501] = 8'hCC;
      for (int i = 0; i < 5; i++) mem[14'h600 + i] = 8'h11;
      start = 1'b1; start_addr = 14'h500; byte_count = 2;
      @(posedge clk); #1; start = 1'b0;
      collect(60, 100, 6, 14'h600, 5);
      n_cmp++; if (n_s !== 16 || got_bits[15:0] !== 16'hCC33) begin n_bad++;
         $display("FAIL ign_bits got=%h/%0d want=cc33/16",
                  got_bits[15:0], n_s); end
      n_cmp++; if (ce_n !== 2 || ce_a[0] !== 14'h500 || ce_a[1] !== 14'h501)
         begin n_bad++;
         $display("FAIL ign_fetch got=%0d %h %h want=2 0500 0501",
                  ce_n, ce_a[0], ce_a[1]); end
      n_cmp++; if (done_n !== 1 || done_c !== first_v + 16) begin n_bad++;
         $display("FAIL ign_done got=%0d@%0d want=1@%0d",
                  done_n, done_c, first_v + 16); end
   endtask

   task automatic test_async_reset();
      logic [AW+5:0] outs;
      start = 1'b1; start_addr = 14'h700; byte_count = 3;
      @(posedge clk); #1; start = 1'b0;
      collect(12, 100, -1, '0, '0);
      n_cmp++; if (busy !== 1'b1 || samp_valid !== 1'b1) begin n_bad++;
         $display("FAIL rst_pre got=%b%b want=11", busy, samp_valid); end
      #2; rst = 1'b0; #1;
      outs = {mem_ce, mem_addr, samp_valid, samp_i, samp_last, busy, done};
      n_cmp++; if (outs !== '0) begin n_bad++;
         $display("FAIL rst_async got=%0h want=0", outs); end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      start = 1'b1; start_addr = 14'h500; byte_count = 2;
      @(posedge clk); #1; start = 1'b0;
      collect(60, 100, -1, '0, '0);
      n_cmp++; if (n_s !== 16 || got_bits[15:0] !== 16'hCC33) begin n_bad++;
         $display("FAIL rst_restart got=%h/%0d want=cc33/16",
                  got_bits[15:0], n_s); end
      n_cmp++; if (done_n !== 1 || ce_n !== 2) begin n_bad++;
         $display("FAIL rst_restart_done got=%0d ce%0d want=1 ce2",
                  done_n, ce_n); end
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i * 37 + 11);
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_zero_len();
      test_abort();
      test_ignored_start();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sample_buf_reader.md
# sample_buf_reader

- Read-side counterpart of the 1-bit IF capture writer.
- Reads packed sample bytes from the capture BSRAM and unpacks them LSB-first (bit k of a byte is sample k, the order the writer packs them).
- Presents a one-bit-per-beat sample stream with valid/ready to the acquisition correlator.
- Sustains one sample per clock while `samp_ready` is held high, using a one-byte prefetch so BSRAM latency stays hidden after the first byte.

## Interface
- `ADDR_W`, 14 — BSRAM byte address width; addresses wrap modulo 2^ADDR_W.
- `RD_LAT`, 1 — BSRAM read latency in clk cycles (1 or 2).
- `clk` in 1 — system clock.
- `rst` in 1 — reset, asynchronous, active-low.
- `start` in 1 — one-cycle request; honoured only when `busy`=0.
- `start_addr` in ADDR_W — first byte address, latched on start.
- `byte_count` in ADDR_W+1 — bytes to read, 0..2^ADDR_W, latched on start.
- `abort` in 1 — synchronous cancel.
- `mem_ce` out 1 — BSRAM read enable.
- `mem_addr` out ADDR_W — BSRAM read address.
- `mem_rdata` in 8 — low byte of the BSRAM data out; valid RD_LAT cycles after the `mem_ce` edge.
- `samp_valid` out 1 — sample present.
- `samp_ready` in 1 — consumer accepts.
- `samp_i` out 1 — sample bit.
- `samp_last` out 1 — final sample of the request.
- `busy` out 1 — request in progress.
- `done` out 1 — one-cycle completion pulse.

## Operation
- Reset value of every output is 0; internal state is IDLE with all counters 0.
- States: IDLE, RUN.
  - IDLE→RUN on `start` with `byte_count`≠0.
  - `start` with `byte_count`=0 pulses `done` on the next cycle, emits no samples and never enters RUN.
  - RUN→IDLE on the last sample handshake or on `abort`.
- Fetch engine, in RUN:
  - Asserts `mem_ce` for one cycle when all of the following hold: fetches remaining >0, no read in flight, and the prefetch buffer is empty or will be loaded into the shifter this cycle.
  - `mem_addr` = `start_addr` + fetch index, mod 2^ADDR_W; it wraps from 2^ADDR_W−1 to 0 silently.
- In-flight tracking:
  - An RD_LAT-deep valid pipe tags each read.
  - `mem_rdata` is captured into the prefetch register only when the tag emerges.
  - `abort` and a return to IDLE clear the pipe, so stale returns are discarded, including those arriving after a new `start`.
- Shifter:
  - Holds the current byte and a 3-bit index.
  - `samp_i` = byte[index]; `samp_valid` = shifter loaded.
  - A handshake (`samp_valid` & `samp_ready`) advances the index.
  - On index 7 handshake, the shifter reloads from prefetch in the same edge if prefetch is valid; otherwise it goes empty (`samp_valid`=0).
  - An empty shifter loads from prefetch as soon as prefetch is valid.
- `samp_last` = 1 only while the final byte is in the shifter and index = 7.
- Stall rule: while `samp_valid`=1 and `samp_ready`=0, `samp_i`, `samp_last` and `samp_valid` stay stable.
- Completion: `done` pulses on the cycle after the final handshake; `busy` falls on that same edge.
- `abort` (any state):
  - Next edge: IDLE, `busy`=0, `samp_valid`=0, `mem_ce`=0, no `done`.
  - `abort` and `start` in the same cycle: `abort` wins; `start` is dropped.
- `start` while `busy`=1 is ignored with no side effect.
- Reset mid-request returns all outputs to their reset values immediately.

## Timing
- `start` sampled at edge T0:
  - `busy`=1 and `mem_ce`=1 after T0 (first fetch in the cycle following T0).
  - Data captured into prefetch at T0+1+RD_LAT.
  - First `samp_valid`=1 after edge T0+RD_LAT+2.
- Throughput: with `samp_ready`=1 continuously, `samp_valid` never drops between bytes (8 cycles per byte > RD_LAT+1). A request of N bytes completes 8N cycles after the first valid.
- At most one read outstanding, and at most two bytes buffered (shifter + prefetch).
- `done` → `start` may be accepted on the cycle `done` is high (`busy` already 0).

## Test plan
- **Basic:** memory [0]=0xA5, [1]=0x3C; `start_addr`=0, `byte_count`=2, `samp_ready`=1.
  - Samples 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
  - `samp_last` only on sample 16; `done` one cycle later; first valid RD_LAT+2 cycles after start.
- **Wrap:** `start_addr`=0x3FFF, `byte_count`=2 with ADDR_W=14 → `mem_addr` sequence 0x3FFF, 0x0000; data bits match those bytes.
- **Backpressure:** `samp_ready` random 30% duty.
  - Sample order identical to the ready=1 run; outputs stable during stalls.
  - No extra `mem_ce` beyond `byte_count`.
- **Zero length:** `byte_count`=0 → `done` pulse next cycle, `samp_valid` never high, `mem_ce` never high.
- **Abort:** `abort` mid byte 3 of 10; immediately `start` with new address.
  - No `done` for the aborted request.
  - The first sample of the new request comes from the new address; no stale byte leaks (check with RD_LAT=2).
- **Reset/ignored start:** `start` pulsed while busy → ignored, count unchanged. Async `rst` low mid-request → all outputs 0 at once; clean restart afterward.
